// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encodings and IO region decode for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 3;

    // Memory-mapped IO (UART) lives where address bits [17:16] are both set.
    localparam int         IO_SEL_HI  = 17;
    localparam int         IO_SEL_LO  = 16;
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] size_bytes(input logic [2:0] size);
        case (size)
            3'd1:    size_bytes = CNT_W'(1);
            3'd2:    size_bytes = CNT_W'(2);
            default: size_bytes = CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ext.sv
// Little-endian byte merge into the read buffer plus zero/sign extension of 1/2/4-byte loads.
module mem_ext
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] word,
    input  logic [7:0]        byte_in,
    input  logic [CNT_W-1:0]  idx,
    input  logic [CNT_W-1:0]  nbytes,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] extended
);

    always_comb begin
        merged = word;
        for (int i = 0; i < DATA_W/8; i++) begin
            if (idx == CNT_W'(i)) merged[8*i +: 8] = byte_in;
        end
        extended = merged;
        case (nbytes)
            CNT_W'(1): extended = {{(DATA_W-8){sign_ext & merged[7]}}, merged[7:0]};
            CNT_W'(2): extended = {{(DATA_W-16){sign_ext & merged[15]}}, merged[15:0]};
            default:   extended = merged;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating store > load > fetch over a single 8-bit RAM port.
//   state    | meaning
//   ST_IDLE  | bus idle, arbitrate new request
//   ST_READ  | issue read addresses, capture bytes one cycle later
//   ST_WRITE | drive one store byte per cycle, stall on full IO buffer
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_size,
    input  logic              ld_signed,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_data,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [2:0]        st_size,
    output logic              st_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] base, addr_cur;
    logic [CNT_W-1:0]  nbytes;
    logic              sign_ext, is_fetch;
    logic [DATA_W-1:0] sdata, rbuf, merged, extended;
    logic              if_done_q, ld_done_q, st_done_q;
    logic              any_done, io_stall;
    logic              accept_st, accept_ld, accept_if;
    logic              capture, fin_rd, fin_wr;

    assign addr_cur = base + ADDR_W'(cnt);
    assign any_done = if_done_q | ld_done_q | st_done_q;
    assign io_stall = (state == ST_WRITE) && io_buffer_full
                      && (addr_cur[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);

    // Done pulses are held through rdy=0 but only visible while enabled.
    assign if_done = if_done_q & rdy;
    assign ld_done = ld_done_q & rdy;
    assign st_done = st_done_q & rdy;

    mem_ext #(.DATA_W(DATA_W)) u_ext (
        .word     (rbuf),
        .byte_in  (mem_din),
        .idx      (cnt - CNT_W'(1)),
        .nbytes   (nbytes),
        .sign_ext (sign_ext),
        .merged   (merged),
        .extended (extended)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        accept_st = 1'b0;
        accept_ld = 1'b0;
        accept_if = 1'b0;
        capture   = 1'b0;
        fin_rd    = 1'b0;
        fin_wr    = 1'b0;
        mem_a     = '0;
        mem_dout  = '0;
        mem_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rdy && !any_done) begin
                    if (st_req) begin
                        accept_st = 1'b1;
                        state_nx  = ST_WRITE;
                        cnt_nx    = '0;
                    end else if (!clear && ld_req) begin
                        accept_ld = 1'b1;
                        state_nx  = ST_READ;
                        cnt_nx    = '0;
                    end else if (!clear && if_req) begin
                        accept_if = 1'b1;
                        state_nx  = ST_READ;
                        cnt_nx    = '0;
                    end
                end
            end
            ST_READ: begin
                // cnt runs one past the last address so the final byte can be captured.
                mem_a = addr_cur;
                if (rdy) begin
                    if (clear) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        capture = (cnt != '0);
                        if (cnt == nbytes) begin
                            fin_rd   = 1'b1;
                            state_nx = ST_IDLE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                end
            end
            ST_WRITE: begin
                mem_a = addr_cur;
                for (int i = 0; i < DATA_W/8; i++) begin
                    if (cnt == CNT_W'(i)) mem_dout = sdata[8*i +: 8];
                end
                mem_wr = rdy && !io_stall;
                if (rdy && !io_stall) begin
                    if (cnt == nbytes - CNT_W'(1)) begin
                        fin_wr   = 1'b1;
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base      <= '0;
            nbytes    <= '0;
            sign_ext  <= 1'b0;
            is_fetch  <= 1'b0;
            sdata     <= '0;
            rbuf      <= '0;
            if_data   <= '0;
            ld_data   <= '0;
            if_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
        end else if (rdy) begin
            if_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            if (accept_st) begin
                base   <= st_addr;
                nbytes <= size_bytes(st_size);
                sdata  <= st_data;
            end else if (accept_ld) begin
                base     <= ld_addr;
                nbytes   <= size_bytes(ld_size);
                sign_ext <= ld_signed;
                is_fetch <= 1'b0;
                rbuf     <= '0;
            end else if (accept_if) begin
                base     <= if_addr;
                nbytes   <= CNT_W'(4);
                sign_ext <= 1'b0;
                is_fetch <= 1'b1;
                rbuf     <= '0;
            end
            if (capture) rbuf <= merged;
            if (fin_rd) begin
                if (is_fetch) begin
                    if_data   <= merged;
                    if_done_q <= 1'b1;
                end else begin
                    ld_data   <= extended;
                    ld_done_q <= 1'b1;
                end
            end
            if (fin_wr) st_done_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: registered byte RAM model, write logger, cycle-accurate done checks.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_req, ld_req, st_req, ld_signed, io_buffer_full;
    logic [31:0] if_addr, ld_addr, st_addr, st_data;
    logic [2:0]  ld_size, st_size;
    logic        if_done, ld_done, st_done, mem_wr;
    logic [31:0] if_data, ld_data, mem_a;
    logic [7:0]  mem_din, mem_dout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ld_pulses = 0;

    logic [7:0]  ram [0:4095];
    logic [31:0] log_a[$];
    logic [7:0]  log_d[$];
    int          log_c[$];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_signed(ld_signed),
        .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_done(st_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        mem_din <= ram[mem_a[11:0]];
    end

    always @(negedge clk) begin
        if (mem_wr) begin
            log_a.push_back(mem_a);
            log_d.push_back(mem_dout);
            log_c.push_back(cyc);
        end
        if (ld_done) ld_pulses = ld_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int rel, input logic [31:0] a, input logic [7:0] d);
        pack = {rel[3:0], a[19:0], d};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // which: 0 fetch, 1 load, 2 store. at = cycle of done relative to call, -1 on timeout.
    task automatic wait_done(input int which, input int max_cyc, output int at,
                             output logic [31:0] data, output logic [31:0] a1);
        logic seen;
        at = -1;
        data = '0;
        a1 = '0;
        for (int n = 0; n <= max_cyc; n++) begin
            @(negedge clk);
            if (n == 1) a1 = mem_a;
            seen = (which == 0) ? if_done : (which == 1) ? ld_done : st_done;
            if (seen) begin
                at = n;
                data = (which == 0) ? if_data : ld_data;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] a, input int exp_at,
                            input logic [31:0] exp_d);
        int at;
        logic [31:0] d, a1;
        if_req = 1'b1;
        if_addr = a;
        wait_done(0, 16, at, d, a1);
        next_cycle();
        if_req = 1'b0;
        check_eq({tag, "_cyc"}, at, exp_at);
        check_eq({tag, "_data"}, d, exp_d);
        check_eq({tag, "_addr1"}, a1, a);
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                           input logic sg, input int exp_at, input logic [31:0] exp_d);
        int at;
        logic [31:0] d, a1;
        ld_req = 1'b1;
        ld_addr = a;
        ld_size = sz;
        ld_signed = sg;
        wait_done(1, 16, at, d, a1);
        next_cycle();
        ld_req = 1'b0;
        check_eq({tag, "_cyc"}, at, exp_at);
        check_eq({tag, "_data"}, d, exp_d);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                            output int at, output int t0, output int n0);
        logic [31:0] dd, a1;
        n0 = log_a.size();
        t0 = cyc;
        st_req = 1'b1;
        st_addr = a;
        st_data = d;
        st_size = sz;
        wait_done(2, 20, at, dd, a1);
        next_cycle();
        st_req = 1'b0;
    endtask

    task automatic check_log(input string tag, input int idx, input int t0, input int rel,
                             input logic [31:0] a, input logic [7:0] d);
        if (idx < log_a.size())
            check_eq(tag, pack(log_c[idx] - t0, log_a[idx], log_d[idx]), pack(rel, a, d));
        else
            check_eq(tag, 32'hFFFF_FFFF, pack(rel, a, d));
    endtask

    initial begin
        int at, t0, n0, p0;
        logic [31:0] d, a1;

        rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; ld_signed = 1'b0;
        if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; ld_size = 3'd4; st_size = 3'd4;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h200] = 8'h80;
        ram[12'h202] = 8'h34; ram[12'h203] = 8'h92;
        ram[12'h204] = 8'h78; ram[12'h205] = 8'h56; ram[12'h206] = 8'h34; ram[12'h207] = 8'h12;
        ram[12'h300] = 8'h93; ram[12'h301] = 8'h00; ram[12'h302] = 8'hA0; ram[12'h303] = 8'h00;
        ram[12'hFFF] = 8'h11; ram[12'h000] = 8'h22;

        // reset state
        st_req = 1'b1; st_addr = 32'h0000_0400; st_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_a", mem_a, 32'h0);
        check_eq("rst_wr_dout", {23'h0, mem_wr, mem_dout}, 32'h0);
        check_eq("rst_dones", {29'h0, if_done, ld_done, st_done}, 32'h0);
        check_eq("rst_if_data", if_data, 32'h0);
        check_eq("rst_ld_data", ld_data, 32'h0);
        st_req = 1'b0;
        rst = 1'b1;
        next_cycle();

        do_fetch("fetch_100", 32'h100, 6, 32'h0000_0513);
        do_load("lb_signed", 32'h200, 3'd1, 1'b1, 3, 32'hFFFF_FF80);
        do_load("lb_unsigned", 32'h200, 3'd1, 1'b0, 3, 32'h0000_0080);
        do_load("lh_signed", 32'h202, 3'd2, 1'b1, 4, 32'hFFFF_9234);
        do_load("lw", 32'h204, 3'd4, 1'b0, 6, 32'h1234_5678);
        do_load("lh_wrap", 32'hFFFF_FFFF, 3'd2, 1'b0, 4, 32'h0000_2211);

        // store wins over simultaneous fetch, fetch served afterwards
        if_req = 1'b1; if_addr = 32'h300;
        do_store(32'h300, 32'hDEAD_BEEF, 3'd4, at, t0, n0);
        check_eq("sw_done_cyc", at, 5);
        check_log("sw_b0", n0,     t0, 1, 32'h300, 8'hEF);
        check_log("sw_b1", n0 + 1, t0, 2, 32'h301, 8'hBE);
        check_log("sw_b2", n0 + 2, t0, 3, 32'h302, 8'hAD);
        check_log("sw_b3", n0 + 3, t0, 4, 32'h303, 8'hDE);
        do_fetch("fetch_after_sw", 32'h300, 6, 32'h00A0_0093);

        // IO store stalled three cycles by full UART buffer
        io_buffer_full = 1'b1;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 io_buffer_full = 1'b0;
            end
        join_none
        do_store(32'h0003_0000, 32'h0000_005A, 3'd1, at, t0, n0);
        check_eq("sb_io_done_cyc", at, 5);
        check_eq("sb_io_wr_count", log_a.size() - n0, 1);
        check_log("sb_io_b0", n0, t0, 4, 32'h0003_0000, 8'h5A);

        // rdy low for two cycles freezes a halfword store
        fork
            begin
                @(posedge clk);
                #1 rdy = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 rdy = 1'b1;
            end
        join_none
        do_store(32'h310, 32'h0000_CAFE, 3'd2, at, t0, n0);
        check_eq("sh_rdy_done_cyc", at, 5);
        check_log("sh_rdy_b0", n0,     t0, 3, 32'h310, 8'hFE);
        check_log("sh_rdy_b1", n0 + 1, t0, 4, 32'h311, 8'hCA);

        // clear during a word load aborts it
        p0 = ld_pulses;
        ld_req = 1'b1; ld_addr = 32'h204; ld_size = 3'd4; ld_signed = 1'b0;
        next_cycle();
        next_cycle();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        check_eq("clr_idle_cyc3", mem_a, 32'h0);
        repeat (8) next_cycle();
        check_eq("clr_no_ld_done", ld_pulses - p0, 0);

        // clear in idle blocks the load for that cycle only
        clear = 1'b1;
        fork
            begin
                @(posedge clk);
                #1 clear = 1'b0;
            end
        join_none
        do_load("clr_idle_lb", 32'h200, 3'd1, 1'b1, 4, 32'hFFFF_FF80);

        // reset in the middle of a word store
        n0 = log_a.size();
        st_req = 1'b1; st_addr = 32'h320; st_data = 32'h0102_0304; st_size = 3'd4;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_mid_pre_wr", {31'h0, mem_wr}, 32'h1);
        #1 rst = 1'b0;
        st_req = 1'b0;
        #1;
        check_eq("rst_mid_wr_dout", {23'h0, mem_wr, mem_dout}, 32'h0);
        check_eq("rst_mid_mem_a", mem_a, 32'h0);
        check_eq("rst_mid_dones", {29'h0, if_done, ld_done, st_done}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) next_cycle();
        check_eq("rst_mid_wr_count", log_a.size() - n0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-006 SHALL have port clear  input  1  pipeline flush from ROB.
REQ-007 SHALL have port if_req  input  1  instruction-fetch request, held until if_done.
REQ-008 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-009 SHALL have port if_done  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port if_data  output  DATA_W  fetched word, valid with if_done.
REQ-011 SHALL have port ld_req  input  1  LSB load request, held until ld_done.
REQ-012 SHALL have port ld_addr  input  ADDR_W  load address.
REQ-013 SHALL have port ld_size  input  3  byte count: 1, 2 or 4.
REQ-014 SHALL have port ld_signed  input  1  sign-extend load result when 1.
REQ-015 SHALL have port ld_done  output  1  one-cycle load completion pulse.
REQ-016 SHALL have port ld_data  output  DATA_W  extended load result, valid with ld_done.
REQ-017 SHALL have port st_req  input  1  committed-store request from ROB, held until st_done.
REQ-018 SHALL have port st_addr  input  ADDR_W  store address.
REQ-019 SHALL have port st_data  input  DATA_W  store data, low bytes used.
REQ-020 SHALL have port st_size  input  3  byte count: 1, 2 or 4.
REQ-021 SHALL have port st_done  output  1  one-cycle store completion pulse.
REQ-022 SHALL have port mem_din  input  8  RAM read byte, returned one cycle after mem_a.
REQ-023 SHALL have port mem_dout  output  8  RAM write byte.
REQ-024 SHALL have port mem_a  output  ADDR_W  RAM byte address.
REQ-025 SHALL have port mem_wr  output  1  RAM write strobe (1 = write).
REQ-026 SHALL have port io_buffer_full  input  1  UART buffer full; stalls IO writes.

Function
REQ-027 SHALL implement states IDLE, READ, WRITE; IDLE->READ on fetch/load accept, IDLE->WRITE on store accept, READ/WRITE->IDLE after last byte.
REQ-028 SHALL arbitrate in IDLE with fixed priority st_req > ld_req > if_req; one transaction at a time, no preemption.
REQ-029 SHALL, for an N-byte read accepted in cycle 0, drive mem_a = base+k in cycle k+1 (k=0..N-1), capture mem_din in cycle k+2, and pulse the requester's done in cycle N+2 with data.
REQ-030 SHALL assemble read bytes little-endian; ld_data zero- or sign-extended from bit 8*N-1 per ld_signed; fetch always N=4.
REQ-031 SHALL, for an N-byte store accepted in cycle 0, drive mem_wr=1, mem_a=base+k, mem_dout=st_data[8k+7:8k] in cycle k+1, and pulse st_done in cycle N+1.
REQ-032 SHALL, when io_buffer_full=1 and mem_a[17:16]=2'b11, hold mem_wr=0 and not advance the byte counter until io_buffer_full=0.
REQ-033 SHALL ignore all requests in the cycle any done pulse is high (requester drops req after done).
REQ-034 SHALL, on clear=1 during READ, abort next cycle, return to IDLE, and emit no if_done/ld_done.
REQ-035 SHALL, on clear=1 during WRITE, complete the store normally (committed store is never dropped).
REQ-036 SHALL, on clear=1 in IDLE, accept only st_req that cycle.
REQ-037 SHALL, while rdy=0, hold state, counter and outputs, force mem_wr=0, emit no done.
REQ-038 SHALL drive mem_a=0, mem_dout=0, mem_wr=0 in IDLE.
REQ-039 SHALL compute base+k modulo 2^ADDR_W (wrap at top of address space).

Reset
REQ-040 SHALL, while rst=0, asynchronously force state IDLE, counter 0, all done outputs 0, if_data=ld_data=0, mem_a=0, mem_dout=0, mem_wr=0.
REQ-041 SHALL, on reset mid-transaction, discard the transaction; first accept occurs no earlier than the first edge after rst rises.

Structure
REQ-042 SHALL take ADDR_W/DATA_W, state encodings and IO_ADDR region constants from the shared defines package.
REQ-043 SHALL place byte assembly and sign/zero extension in one combinational sub-module mem_ext.

Verification
REQ-044 SHALL test fetch if_addr=0x100, RAM bytes 13 05 00 00 -> if_done in cycle 6, if_data=0x00000513.
REQ-045 SHALL test LB ld_addr=0x200 byte 0x80, ld_signed=1 -> ld_data=0xFFFFFF80; ld_signed=0 -> 0x00000080.
REQ-046 SHALL test simultaneous st_req (SW 0x300, 0xDEADBEEF) and if_req -> bytes EF BE AD DE written at 0x300..0x303 first, st_done cycle 5, then fetch served.
REQ-047 SHALL test SB to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for 3 cycles, st_done delayed by 3.
REQ-048 SHALL test clear in cycle 2 of LW -> no ld_done, IDLE in cycle 3; rst low mid-SW -> all outputs 0 immediately.
